// File: rtl/nbcac_13di_pkg.sv
// nbcac_13di_pkg: shared widths, weight table and FSM states for the NBCAC 13-bit encoder
package nbcac_13di_pkg;
  localparam int NBCAC_V_W = 13;
  localparam int NBCAC_D_W = 18;
  localparam int NBCAC_NSTAGE = 16;
  localparam logic [NBCAC_V_W-1:0] S [1:18] = '{
    13'd1, 13'd3194, 13'd1974, 13'd1220, 13'd754, 13'd466, 13'd288, 13'd178, 13'd110,
    13'd68, 13'd42, 13'd26, 13'd16, 13'd10, 13'd6, 13'd4, 13'd2, 13'd2
  };
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/nbcac_13di_stage.sv
// nbcac_13di_stage: one combinational NBCAC decision step producing d[k] and the residue
module nbcac_13di_stage
  import nbcac_13di_pkg::*;
(
  input  logic [NBCAC_V_W-1:0] r,
  input  logic                 d_prev,
  input  logic [NBCAC_V_W-1:0] s_k,
  input  logic [NBCAC_V_W-1:0] s_k1,
  output logic                 d_k,
  output logic [NBCAC_V_W-1:0] r_next
);
  logic [NBCAC_V_W-1:0] sum;
  assign sum = s_k + s_k1;
  assign d_k = (r >= sum) ? 1'b1 : (r < s_k) ? 1'b0 : d_prev;
  assign r_next = d_k ? r - s_k : r;
endmodule

// File: rtl/nbcac_13di_encoder_seq.sv
// nbcac_13di_encoder_seq: multi-cycle NBCAC 13->18 encoder with valid/ready on both sides
module nbcac_13di_encoder_seq
  import nbcac_13di_pkg::*;
#(
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBCAC_V_W-1:0] in_data,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NBCAC_D_W-1:0] out_code,
  output logic                 busy
);
  localparam int NG = NBCAC_NSTAGE / STAGES_PER_CYCLE;
  localparam logic [3:0] LAST = 4'(NG - 1);
  state_t state, state_nx;
  logic [NBCAC_V_W-1:0] r, r_nx;
  logic [NBCAC_D_W-1:0] d, d_nx;
  logic [3:0] cnt, cnt_nx;
  logic [4:0] base;
  logic [NBCAC_V_W-1:0] rc [0:STAGES_PER_CYCLE];
  logic [STAGES_PER_CYCLE:0] dc;
  assign base = 5'(int'(cnt) * STAGES_PER_CYCLE);
  assign rc[0] = r;
  assign dc[0] = d[base];
  genvar i;
  generate
    for (i = 0; i < STAGES_PER_CYCLE; i++) begin : g_lane
      logic [4:0] k;
      assign k = base + 5'(i + 2);
      nbcac_13di_stage u_stage (
        .r(rc[i]),
        .d_prev(dc[i]),
        .s_k(S[k]),
        .s_k1(S[k + 5'd1]),
        .d_k(dc[i+1]),
        .r_next(rc[i+1])
      );
    end
  endgenerate
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_code = d;
  // next-state: accept in IDLE, run stage groups, hold result until taken, abort flushes
  always_comb begin
    state_nx = state;
    r_nx = r;
    d_nx = d;
    cnt_nx = cnt;
    if (state == IDLE) begin
      if (in_valid && !abort) begin
        state_nx = RUN;
        d_nx = {17'd0, in_data[0]};
        r_nx = in_data - {12'd0, in_data[0]};
        cnt_nx = 4'd0;
      end
    end else if (abort) begin
      state_nx = IDLE;
      cnt_nx = 4'd0;
    end else if (state == RUN) begin
      for (int j = 0; j < STAGES_PER_CYCLE; j++) d_nx[base + 5'(j) + 5'd1] = dc[j+1];
      r_nx = rc[STAGES_PER_CYCLE];
      if (cnt == LAST) begin
        d_nx[17] = rc[STAGES_PER_CYCLE] != '0;
        state_nx = DONE;
      end else cnt_nx = cnt + 4'd1;
    end else if (out_ready) state_nx = IDLE;
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      r <= '0;
      d <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      r <= r_nx;
      d <= d_nx;
      cnt <= cnt_nx;
    end
  end
endmodule
